scpu: RTL and testbench
=======================

# scpu

Single-cycle RV32I-subset processor core (SCPU) for the lab SoC. Fetches one instruction per clock from an asynchronous instruction memory addressed by `PC_out[11:2]`, and executes it in the same cycle. Accesses a word-wide data memory that the SoC clocks on `~clk`. Sits between the instruction ROM, the data RAM and the memory-mapped I/O fabric.

## Interface
- No parameters.
- `clk`  in  1  system clock; all core state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `inst_in`  in  32  instruction at `PC_out`, combinational from the instruction memory.
- `Data_in`  in  32  load data for `Addr_out`, valid before the next rising `clk`.
- `MIO_ready`  in  1  memory/I-O ready; 0 stalls the core.
- `MemRW`  out  1  data-memory write enable (1 = store this cycle).
- `CPU_MIO`  out  1  high when the current instruction is a load or store.
- `Addr_out`  out  32  data address, rs1 + imm.
- `Data_out`  out  32  store data, rs2.
- `PC_out`  out  32  current program counter.
- `dbg_reg_addr`  in  5  debug register select; present only with `SCPU_DEBUG_EN`.
- `dbg_reg_data`  out  32  value of the selected register; present only with `SCPU_DEBUG_EN`.

## Operation
- **State:** PC (32 b) and 32×32 register file.
  - x0 reads 0 and ignores writes.
  - Register reads are combinational; writes occur on the rising edge.
- **Instruction set:**
  - R-type: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - I-type ALU: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - Memory: lw, sw.
  - Branches: beq, bne, blt, bge, bltu, bgeu.
  - Jumps: jal, jalr.
  - Upper immediates: lui, auipc.
- **Immediates:** sign-extended per RV32I I/S/B/U/J formats. Shift amounts use the low 5 bits.
- **Arithmetic:** all 32-bit modulo 2^32, with no overflow traps.
  - slt/blt/bge compare signed.
  - sltu/bltu/bgeu compare unsigned.
- **Next PC:**
  - Default: PC+4.
  - Taken branch: PC+immB.
  - jal: PC+immJ.
  - jalr: (rs1+immI) & ~1.
  - jal/jalr write PC+4 to rd. The PC wraps at 2^32.
- **Loads and stores:**
  - lw writes `Data_in` to rd.
  - sw drives `Addr_out` = rs1+immS, `Data_out` = rs2 and `MemRW` = 1.
  - Only whole words are supported; `Addr_out[1:0]` is passed through unmodified and the memory ignores it.
- **Other encodings:** any unsupported or illegal encoding executes as a NOP (PC+4, no register write, `MemRW` = 0).
- **Stall:** while `MIO_ready` = 0, the PC holds, register writes are suppressed and `MemRW` is forced to 0.
- **Reset:** a rising edge with `rst` = 1 sets PC = 0 and clears all registers. While `rst` is high:
  - `MemRW`, `CPU_MIO`, `Addr_out` and `Data_out` are 0.
  - `PC_out` is 0 from the first reset edge.

## Timing
- Single cycle per instruction, with no pipeline, hazards or forwarding.
- `Addr_out`, `Data_out`, `MemRW` and `CPU_MIO` are combinational from `inst_in` and the register file, and stable for the whole cycle.
- The SoC writes data memory on the falling edge. `Data_in` for lw is valid after the falling edge and is captured into rd on the next rising edge.
- A write to rd and a read of the same register in the following instruction returns the new value, because the write completes at the edge between them.
- If `rst` is asserted mid-program, the state is cleared at the next rising edge. Any store in the reset cycle is suppressed.
- `rst` and `MIO_ready` = 0 together: reset wins.

## Configuration
- **`SCPU_DEBUG_EN` defined:**
  - Ports `dbg_reg_addr` and `dbg_reg_data` exist.
  - `dbg_reg_data` = register[`dbg_reg_addr`], combinational, and reads 0 for x0.
- **`SCPU_DEBUG_EN` undefined:** the ports are absent and the core behaviour is otherwise identical.

## Test plan
- **Reset:** reset, then `addi x1,x0,5`; `addi x2,x1,-7` → x1 = 5, x2 = 0xFFFFFFFE, `PC_out` = 8 after two cycles.
- **Store/load:** `lui x3,0x12345`; `addi x3,x3,0x678`; `sw x3,16(x0)`; `lw x4,16(x0)`.
  - During the sw cycle: `MemRW` = 1, `Addr_out` = 0x10, `Data_out` = 0x12345678.
  - After lw: x4 = 0x12345678 and `CPU_MIO` = 1 on both instructions.
- **Branch:** x5 = −1, x6 = 1.
  - `blt x5,x6,+8` is taken, so PC goes from 0x20 to 0x28.
  - `bltu x5,x6,+8` is not taken, so PC goes from 0x28 to 0x2C.
- **Jumps:** `jal x1,+12` at 0x40 → PC = 0x4C, x1 = 0x44. Then `jalr x0,0(x1)` → PC = 0x44.
- **Stall and x0:** hold `MIO_ready` = 0 for 3 cycles during `sw` → PC is unchanged and `MemRW` = 0. `addi x0,x0,9` leaves x0 = 0.
- **Reset mid-program:** assert `rst` at PC = 0x30 during a sw → no store, PC = 0 and all registers 0 at the next edge.

Source files
------------

// File: rtl/scpu.sv
// Single-cycle RV32I-subset core: combinational fetch/decode/execute, PC and register file on rising clk.
// Define SCPU_DEBUG_EN to add the dbg_reg_addr/dbg_reg_data register read-back port.
module scpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_in,
    input  logic [31:0] Data_in,
    input  logic        MIO_ready,
    output logic        MemRW,
    output logic        CPU_MIO,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic [31:0] PC_out
`ifdef SCPU_DEBUG_EN
    ,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data
`endif
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'h33,
        OPC_OPIMM  = 7'h13,
        OPC_LOAD   = 7'h03,
        OPC_STORE  = 7'h23,
        OPC_BRANCH = 7'h63,
        OPC_JAL    = 7'h6F,
        OPC_JALR   = 7'h67,
        OPC_LUI    = 7'h37,
        OPC_AUIPC  = 7'h17
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        WB_ALU, WB_MEM, WB_LINK, WB_LUI, WB_AUIPC
    } wb_sel_t;

    logic [31:0] pc;
    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    assign opcode = inst_in[6:0];
    assign funct3 = inst_in[14:12];
    assign funct7 = inst_in[31:25];
    assign rd     = inst_in[11:7];
    assign rs1    = inst_in[19:15];
    assign rs2    = inst_in[24:20];

    assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
    assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
    assign imm_b = {{20{inst_in[31]}}, inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
    assign imm_u = {inst_in[31:12], 12'b0};
    assign imm_j = {{12{inst_in[31]}}, inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    logic        reg_we, use_imm, alu_alt;
    logic        is_load, is_store, is_branch, is_jal, is_jalr;
    wb_sel_t     wb_sel;
    logic [31:0] mem_imm;

    // Anything not matched below falls through with every enable low, i.e. a NOP.
    always_comb begin
        reg_we    = 1'b0;
        use_imm   = 1'b0;
        alu_alt   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        wb_sel    = WB_ALU;
        mem_imm   = imm_i;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    reg_we  = 1'b1;
                    alu_alt = funct7[5];
                end
            end
            OPC_OPIMM: begin
                use_imm = 1'b1;
                case (funct3)
                    3'b001:  reg_we = (funct7 == 7'h00);
                    3'b101: begin
                        reg_we  = (funct7 == 7'h00) || (funct7 == 7'h20);
                        alu_alt = funct7[5];
                    end
                    default: reg_we = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    is_load = 1'b1;
                    reg_we  = 1'b1;
                    wb_sel  = WB_MEM;
                end
            end
            OPC_STORE: begin
                is_store = (funct3 == 3'b010);
                mem_imm  = imm_s;
            end
            OPC_BRANCH: is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPC_JAL: begin
                is_jal = 1'b1;
                reg_we = 1'b1;
                wb_sel = WB_LINK;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    is_jalr = 1'b1;
                    reg_we  = 1'b1;
                    wb_sel  = WB_LINK;
                end
            end
            OPC_LUI: begin
                reg_we = 1'b1;
                wb_sel = WB_LUI;
            end
            OPC_AUIPC: begin
                reg_we = 1'b1;
                wb_sel = WB_AUIPC;
            end
            default: ;
        endcase
    end

    alu_op_t     alu_op;
    logic [31:0] op_b, alu_res;
    logic [4:0]  shamt;

    assign op_b  = use_imm ? imm_i : rs2_val;
    assign shamt = op_b[4:0];

    always_comb begin
        case (funct3)
            3'b000:  alu_op = alu_alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alu_alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs1_val + op_b;
            ALU_SUB:  alu_res = rs1_val - op_b;
            ALU_SLL:  alu_res = rs1_val << shamt;
            ALU_SLT:  alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'b0, rs1_val < op_b};
            ALU_XOR:  alu_res = rs1_val ^ op_b;
            ALU_SRL:  alu_res = rs1_val >> shamt;
            ALU_SRA:  alu_res = $signed(rs1_val) >>> shamt;
            ALU_OR:   alu_res = rs1_val | op_b;
            ALU_AND:  alu_res = rs1_val & op_b;
            default:  alu_res = '0;
        endcase
    end

    logic        br_taken;
    logic [31:0] pc_plus4, next_pc, wb_data;

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = $signed(rs1_val) <  $signed(rs2_val);
            3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_taken = rs1_val <  rs2_val;
            3'b111:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (is_jal)
            next_pc = pc + imm_j;
        else if (is_jalr)
            next_pc = (rs1_val + imm_i) & 32'hFFFF_FFFE;
        else if (is_branch && br_taken)
            next_pc = pc + imm_b;
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:   wb_data = Data_in;
            WB_LINK:  wb_data = pc_plus4;
            WB_LUI:   wb_data = imm_u;
            WB_AUIPC: wb_data = pc + imm_u;
            default:  wb_data = alu_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            for (int unsigned i = 0; i < 32; i++)
                rf[i[4:0]] <= '0;
        end else if (MIO_ready) begin
            pc <= next_pc;
            if (reg_we && rd != 5'd0)
                rf[rd] <= wb_data;
        end
    end

    // Bus outputs are held quiet for the whole reset cycle so no store escapes.
    assign MemRW    = is_store & MIO_ready & ~rst;
    assign CPU_MIO  = (is_load | is_store) & ~rst;
    assign Addr_out = rst ? '0 : rs1_val + mem_imm;
    assign Data_out = rst ? '0 : rs2_val;
    assign PC_out   = pc;

`ifdef SCPU_DEBUG_EN
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : rf[dbg_reg_addr];
`endif

endmodule

// File: tb/tb_scpu.sv
// Bench for scpu: directed cycle table for the test-plan program, then random programs
// checked against an instruction-level model; registers are read back by injecting sw probes.
module tb_scpu;

    logic        clk = 1'b0;
    logic        rst, MIO_ready;
    logic [31:0] inst_in, Data_in;
    logic        MemRW, CPU_MIO;
    logic [31:0] Addr_out, Data_out, PC_out;

    logic [31:0] imem [1024];
    logic [31:0] dmem [256];
    logic        probe_en = 1'b0;
    logic [31:0] probe_inst = '0;

    assign inst_in = probe_en ? probe_inst : imem[PC_out[11:2]];
    assign Data_in = dmem[Addr_out[9:2]];

    always #5 clk = ~clk;

    scpu dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .Data_in(Data_in), .MIO_ready(MIO_ready),
        .MemRW(MemRW), .CPU_MIO(CPU_MIO), .Addr_out(Addr_out), .Data_out(Data_out), .PC_out(PC_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // ---------------- reference model (instruction-set level) ----------------
    logic [31:0] mregs [32];
    logic [31:0] mmem  [256];
    logic [31:0] mpc;
    logic [31:0] e_npc, e_wv, e_addr, e_sdata;
    logic [4:0]  e_rd;
    bit          e_we, e_store, e_mio;

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input bit alt, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return sa >>> b[4:0];
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_exec(input logic [31:0] ins);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] a, b, immI, immS, immB, immU, immJ;
        bit          cond;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        a  = mregs[ins[19:15]]; b = mregs[ins[24:20]];
        immI = $signed(ins) >>> 20;
        immS = {immI[31:5], ins[11:7]};
        immB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        immU = {ins[31:12], 12'b0};
        immJ = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e_npc = mpc + 32'd4; e_rd = ins[11:7]; e_we = 0; e_wv = '0;
        e_store = 0; e_mio = 0; e_addr = '0; e_sdata = '0;
        case (op)
            7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                e_we = 1; e_wv = m_alu(f3, f7[5], a, b);
            end
            7'h13: begin
                e_we = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                e_wv = m_alu(f3, (f3 == 3'd5) && f7[5], a, immI);
            end
            7'h03: if (f3 == 3'd2) begin
                e_mio = 1; e_addr = a + immI; e_we = 1; e_wv = mmem[e_addr[9:2]];
            end
            7'h23: if (f3 == 3'd2) begin
                e_mio = 1; e_store = 1; e_addr = a + immS; e_sdata = b;
            end
            7'h63: begin
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = $signed(a) < $signed(b);
                    3'd5: cond = $signed(a) >= $signed(b);
                    3'd6: cond = a < b;
                    3'd7: cond = a >= b;
                    default: cond = 0;
                endcase
                if (cond) e_npc = mpc + immB;
            end
            7'h6F: begin e_we = 1; e_wv = mpc + 32'd4; e_npc = mpc + immJ; end
            7'h67: if (f3 == 3'd0) begin
                e_we = 1; e_wv = mpc + 32'd4; e_npc = (a + immI) & ~32'd1;
            end
            7'h37: begin e_we = 1; e_wv = immU; end
            7'h17: begin e_we = 1; e_wv = mpc + immU; end
            default: ;
        endcase
    endtask

    task automatic model_commit(input bit r, input bit rdy);
        if (r) begin
            mpc = '0;
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else if (rdy) begin
            if (e_store) mmem[e_addr[9:2]] = e_sdata;
            if (e_we && e_rd != 5'd0) mregs[e_rd] = e_wv;
            mpc = e_npc;
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
        f3 = 3'($urandom_range(0, 7));
        imm = $urandom;
        case ($urandom_range(0, 10))
            0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rs2, rs1, f3, rd);
            2, 3: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            4: return enc_u(imm[19:0], rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
            5: return enc_i(imm, rs1, 3'd2, rd, 7'h03);
            6: return enc_s(imm, rs2, rs1, 3'd2);
            7: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd4;
                return enc_b(imm, rs2, rs1, f3);
            end
            8: return enc_j(imm, rd);
            9: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
            default: return $urandom;
        endcase
    endfunction

    // Probes stall the core, so clock edges that pass during a probe change nothing.
    task automatic probe_begin();
        rst = 1'b0; MIO_ready = 1'b0; probe_en = 1'b1;
    endtask
    task automatic probe_reg(input logic [4:0] n, input logic [31:0] exp);
        probe_inst = enc_s(32'd0, n, 5'd0, 3'd2);
        #1;
        chk($sformatf("reg_x%0d", n), Data_out, exp);
    endtask
    task automatic probe_end();
        probe_en = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          r;
        bit          rdy;
        logic [31:0] pc;
        bit          rw;
        bit          mio;
        bit          chk_ad;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t vt [22];

    initial begin
        vt[0]  = '{0, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0};
        vt[1]  = '{0, 1, 32'h04, 0, 0, 0, 32'h0, 32'h0};
        vt[2]  = '{0, 1, 32'h08, 0, 0, 0, 32'h0, 32'h0};
        vt[3]  = '{0, 1, 32'h0C, 0, 0, 0, 32'h0, 32'h0};
        vt[4]  = '{0, 1, 32'h10, 1, 1, 1, 32'h10, 32'h12345678};
        vt[5]  = '{0, 1, 32'h14, 0, 1, 0, 32'h0, 32'h0};
        vt[6]  = '{0, 1, 32'h18, 0, 0, 0, 32'h0, 32'h0};
        vt[7]  = '{0, 1, 32'h1C, 0, 0, 0, 32'h0, 32'h0};
        vt[8]  = '{0, 1, 32'h20, 0, 0, 0, 32'h0, 32'h0};
        vt[9]  = '{0, 1, 32'h28, 0, 0, 0, 32'h0, 32'h0};
        vt[10] = '{0, 1, 32'h2C, 0, 0, 0, 32'h0, 32'h0};
        vt[11] = '{0, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0};
        vt[12] = '{0, 1, 32'h4C, 0, 0, 0, 32'h0, 32'h0};
        vt[13] = '{0, 1, 32'h44, 0, 0, 0, 32'h0, 32'h0};
        vt[14] = '{0, 1, 32'h50, 0, 0, 0, 32'h0, 32'h0};
        vt[15] = '{0, 0, 32'h54, 0, 1, 1, 32'h14, 32'h12345678};
        vt[16] = '{0, 0, 32'h54, 0, 1, 1, 32'h14, 32'h12345678};
        vt[17] = '{0, 0, 32'h54, 0, 1, 1, 32'h14, 32'h12345678};
        vt[18] = '{0, 1, 32'h54, 1, 1, 1, 32'h14, 32'h12345678};
        vt[19] = '{0, 1, 32'h58, 0, 0, 0, 32'h0, 32'h0};
        vt[20] = '{1, 1, 32'h30, 0, 0, 1, 32'h0, 32'h0};
        vt[21] = '{0, 1, 32'h00, 0, 0, 0, 32'h0, 32'h0};

        for (int i = 0; i < 1024; i++) imem[i] = '0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        imem[0]  = enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        imem[1]  = enc_i(32'hFFFFFFF9, 5'd1, 3'd0, 5'd2, 7'h13);
        imem[2]  = enc_u(20'h12345, 5'd3, 7'h37);
        imem[3]  = enc_i(32'h678, 5'd3, 3'd0, 5'd3, 7'h13);
        imem[4]  = enc_s(32'd16, 5'd3, 5'd0, 3'd2);
        imem[5]  = enc_i(32'd16, 5'd0, 3'd2, 5'd4, 7'h03);
        imem[6]  = enc_i(32'hFFFFFFFF, 5'd0, 3'd0, 5'd5, 7'h13);
        imem[7]  = enc_i(32'd1, 5'd0, 3'd0, 5'd6, 7'h13);
        imem[8]  = enc_b(32'd8, 5'd6, 5'd5, 3'd4);
        imem[9]  = enc_i(32'd1, 5'd0, 3'd0, 5'd7, 7'h13);
        imem[10] = enc_b(32'd8, 5'd6, 5'd5, 3'd6);
        imem[11] = enc_j(32'h14, 5'd0);
        imem[12] = enc_s(32'd0, 5'd3, 5'd0, 3'd2);
        imem[16] = enc_j(32'd12, 5'd1);
        imem[17] = enc_j(32'd12, 5'd0);
        imem[19] = enc_i(32'd0, 5'd1, 3'd0, 5'd0, 7'h67);
        imem[20] = enc_i(32'd9, 5'd0, 3'd0, 5'd0, 7'h13);
        imem[21] = enc_s(32'd20, 5'd3, 5'd0, 3'd2);
        imem[22] = enc_j(32'hFFFFFFD8, 5'd0);

        rst = 1'b1; MIO_ready = 1'b1;
        @(posedge clk); #1;
        chk("reset_pc", PC_out, 32'h0);
        chk("reset_memrw", 32'(MemRW), 32'h0);
        chk("reset_mio", 32'(CPU_MIO), 32'h0);
        chk("reset_addr", Addr_out, 32'h0);
        chk("reset_data", Data_out, 32'h0);
        @(posedge clk); #1;
        probe_begin();
        for (int n = 0; n < 32; n++) probe_reg(5'(n), 32'h0);
        probe_end();

        for (int i = 0; i < 22; i++) begin
            if (i == 2) begin
                probe_begin();
                probe_reg(5'd1, 32'd5);
                probe_reg(5'd2, 32'hFFFFFFFE);
                probe_end();
            end
            if (i == 19) begin
                probe_begin();
                probe_reg(5'd0, 32'h0);
                probe_reg(5'd1, 32'h44);
                probe_reg(5'd2, 32'hFFFFFFFE);
                probe_reg(5'd3, 32'h12345678);
                probe_reg(5'd4, 32'h12345678);
                probe_reg(5'd5, 32'hFFFFFFFF);
                probe_reg(5'd6, 32'h1);
                probe_reg(5'd7, 32'h0);
                probe_end();
            end
            if (i == 21) begin
                probe_begin();
                for (int n = 0; n < 32; n++) probe_reg(5'(n), 32'h0);
                probe_end();
            end
            rst = vt[i].r; MIO_ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("dir%0d_pc", i), PC_out, vt[i].pc);
            chk($sformatf("dir%0d_memrw", i), 32'(MemRW), 32'(vt[i].rw));
            chk($sformatf("dir%0d_mio", i), 32'(CPU_MIO), 32'(vt[i].mio));
            if (vt[i].chk_ad) begin
                chk($sformatf("dir%0d_addr", i), Addr_out, vt[i].addr);
                chk($sformatf("dir%0d_data", i), Data_out, vt[i].data);
            end
            if (MemRW) dmem[Addr_out[9:2]] = Data_out;
            @(posedge clk); #1;
        end
        chk("no_store_in_reset", dmem[0], 32'h0);
        chk("stored_word", dmem[5], 32'h12345678);

        for (int i = 0; i < 1024; i++) imem[i] = rand_inst();
        for (int i = 0; i < 256; i++) begin
            dmem[i] = $urandom;
            mmem[i] = dmem[i];
        end
        rst = 1'b1; MIO_ready = 1'b1;
        @(posedge clk); #1;
        model_commit(1'b1, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            bit r, rdy;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 4) != 0);
            rst = r; MIO_ready = rdy;
            model_exec(imem[mpc[11:2]]);
            @(negedge clk);
            chk("rnd_pc", PC_out, mpc);
            chk("rnd_memrw", 32'(MemRW), 32'(!r && e_store && rdy));
            chk("rnd_mio", 32'(CPU_MIO), 32'(!r && e_mio));
            if (r) begin
                chk("rnd_rst_addr", Addr_out, 32'h0);
                chk("rnd_rst_data", Data_out, 32'h0);
            end else if (e_mio) begin
                chk("rnd_addr", Addr_out, e_addr);
                if (e_store) chk("rnd_sdata", Data_out, e_sdata);
            end
            if (MemRW) dmem[Addr_out[9:2]] = Data_out;
            @(posedge clk); #1;
            model_commit(r, rdy);
            if (n % 300 == 299) begin
                probe_begin();
                for (int k = 0; k < 32; k++) probe_reg(5'(k), mregs[k]);
                probe_end();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
